// File: rtl/div_clk_monitor_if.sv
// Signal bundle between a divided-clock source and its monitor.
// The master drives the divided clock and error clear; the slave reports lock and measurements.
interface div_clk_monitor_if #(
  parameter int CNT_W = 8
);
  logic             div_clk_in;
  logic             err_clr;
  logic             locked;
  logic             meas_valid;
  logic [CNT_W-1:0] period_meas;
  logic [CNT_W-1:0] high_meas;
  logic             err;
  logic [15:0]      err_cnt;

  modport master (
    output div_clk_in, err_clr,
    input  locked, meas_valid, period_meas, high_meas, err, err_cnt
  );

  modport slave (
    input  div_clk_in, err_clr,
    output locked, meas_valid, period_meas, high_meas, err, err_cnt
  );
endinterface

// File: rtl/div_clk_monitor.sv
// Self-test for a ripple clock divider: measures period and high time of the divided clock
// in clk cycles, checks them against DIV/TOL, tracks lock and counts errors and timeouts.
module div_clk_monitor #(
  parameter int DIV      = 8,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 32,
  parameter int CNT_W    = 8
) (
  input logic              clk,
  input logic              rst,
  div_clk_monitor_if.slave mon
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(DIV - TOL);
  localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(DIV + TOL);
  localparam logic [CNT_W-1:0] HI_MIN  = CNT_W'(DIV / 2 - TOL);
  localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'(DIV / 2 + TOL);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    GOOD_TARGET = GW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [GW-1:0]    good_cnt, good_cnt_nxt;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic             rise, good, timeout;
  logic             meas_nxt, err_nxt;

  assign rise    = s2 & ~s3;
  assign good    = (per_cnt >= PER_MIN) && (per_cnt <= PER_MAX) &&
                   (hi_cnt >= HI_MIN) && (hi_cnt <= HI_MAX);
  assign timeout = (per_cnt >= TO_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
    end
  end

  // A rise always takes priority over a coincident timeout.
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    meas_nxt     = 1'b0;
    err_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt    = ACQ;
          good_cnt_nxt = '0;
        end
      end
      ACQ: begin
        if (rise) begin
          meas_nxt = 1'b1;
          if (good) begin
            good_cnt_nxt = good_cnt + GW'(1);
            if (good_cnt_nxt == GOOD_TARGET) state_nxt = LOCKED;
          end else begin
            err_nxt      = 1'b1;
            good_cnt_nxt = '0;
          end
        end else if (timeout) begin
          err_nxt      = 1'b1;
          good_cnt_nxt = '0;
          state_nxt    = IDLE;
        end
      end
      LOCKED: begin
        if (rise) begin
          meas_nxt = 1'b1;
          if (!good) begin
            err_nxt      = 1'b1;
            good_cnt_nxt = '0;
            state_nxt    = ACQ;
          end
        end else if (timeout) begin
          err_nxt      = 1'b1;
          good_cnt_nxt = '0;
          state_nxt    = IDLE;
        end
      end
      default: begin
        state_nxt    = IDLE;
        good_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1              <= 1'b0;
      s2              <= 1'b0;
      s3              <= 1'b0;
      per_cnt         <= '0;
      hi_cnt          <= '0;
      mon.locked      <= 1'b0;
      mon.meas_valid  <= 1'b0;
      mon.period_meas <= '0;
      mon.high_meas   <= '0;
      mon.err         <= 1'b0;
      mon.err_cnt     <= '0;
    end else begin
      s1 <= mon.div_clk_in;
      s2 <= s1;
      s3 <= s2;

      if (rise) per_cnt <= CNT_W'(1);
      else if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_W'(1);

      if (rise) hi_cnt <= CNT_W'(1);
      else if (s2 && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CNT_W'(1);

      mon.meas_valid <= meas_nxt;
      mon.err        <= err_nxt;
      mon.locked     <= (state_nxt == LOCKED);
      if (meas_nxt) begin
        mon.period_meas <= per_cnt;
        mon.high_meas   <= hi_cnt;
      end

      // A clear coinciding with a new error leaves that error counted.
      if (mon.err_clr) mon.err_cnt <= err_nxt ? 16'd1 : 16'd0;
      else if (err_nxt && mon.err_cnt != 16'hFFFF) mon.err_cnt <= mon.err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor: drives shaped divided clocks and checks
// measurement, lock, error and timeout behaviour with hand-computed expectations.
module tb_div_clk_monitor;

  logic clk;
  logic rst;

  div_clk_monitor_if #(.CNT_W(8)) mon_if ();

  div_clk_monitor #(
    .DIV(8), .TOL(1), .LOCK_CNT(4), .TIMEOUT(32), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-call observations gathered while driving the divided clock.
  int         stepIdx;
  int         measCount;
  int         errCount;
  int         lockRiseIdx;
  int         lastGap;
  int         lastMeasStep;
  int         errStep;
  logic [7:0] lastPeriod;
  logic [7:0] lastHigh;
  logic [7:0] errPeriod;
  logic       errLocked;
  logic       prevLocked;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic resetStats();
    stepIdx      = 0;
    measCount    = 0;
    errCount     = 0;
    lockRiseIdx  = 0;
    lastGap      = 0;
    lastMeasStep = 0;
    errStep      = -1;
    lastPeriod   = '0;
    lastHigh     = '0;
    errPeriod    = '0;
    errLocked    = 1'b0;
    prevLocked   = mon_if.locked;
  endtask

  task automatic driveCycle(input logic d, input logic c);
    mon_if.div_clk_in = d;
    mon_if.err_clr    = c;
    @(negedge clk);
    if (mon_if.meas_valid) begin
      measCount++;
      if (measCount > 1) lastGap = stepIdx - lastMeasStep;
      lastMeasStep = stepIdx;
      lastPeriod   = mon_if.period_meas;
      lastHigh     = mon_if.high_meas;
    end
    if (mon_if.err) begin
      if (errCount == 0) begin
        errStep   = stepIdx;
        errLocked = mon_if.locked;
        errPeriod = mon_if.period_meas;
      end
      errCount++;
    end
    if (mon_if.locked && !prevLocked) lockRiseIdx = measCount;
    prevLocked = mon_if.locked;
    stepIdx++;
  endtask

  // Drives n periods of 'per' cycles, high for the first 'hi'; err_clr on step clrStep.
  task automatic applyStimulus(input int per, input int hi, input int n, input int clrStep);
    resetStats();
    for (int p = 0; p < n; p++)
      for (int j = 0; j < per; j++)
        driveCycle(j < hi, stepIdx == clrStep);
    mon_if.err_clr = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    mon_if.div_clk_in = 1'b0;
    mon_if.err_clr    = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_locked", 32'(mon_if.locked), 0);
    checkOutput("rst_meas_valid", 32'(mon_if.meas_valid), 0);
    checkOutput("rst_err", 32'(mon_if.err), 0);
    checkOutput("rst_period", 32'(mon_if.period_meas), 0);
    checkOutput("rst_high", 32'(mon_if.high_meas), 0);
    checkOutput("rst_err_cnt", 32'(mon_if.err_cnt), 0);
    rst = 1'b0;

    $display("[TB] clean /8 acquisition");
    applyStimulus(8, 4, 5, -1);
    checkOutput("t1_meas_count", 32'(measCount), 4);
    checkOutput("t1_lock_at_meas", 32'(lockRiseIdx), 4);
    checkOutput("t1_err_count", 32'(errCount), 0);
    checkOutput("t1_period", 32'(lastPeriod), 8);
    checkOutput("t1_high", 32'(lastHigh), 4);
    checkOutput("t1_gap", 32'(lastGap), 8);
    checkOutput("t1_locked", 32'(mon_if.locked), 1);

    $display("[TB] stretched period");
    applyStimulus(10, 5, 1, -1);
    checkOutput("t2a_err_count", 32'(errCount), 0);
    checkOutput("t2a_locked", 32'(mon_if.locked), 1);
    applyStimulus(8, 4, 5, -1);
    checkOutput("t2_err_count", 32'(errCount), 1);
    checkOutput("t2_err_period", 32'(errPeriod), 10);
    checkOutput("t2_err_locked", 32'(errLocked), 0);
    checkOutput("t2_err_cnt", 32'(mon_if.err_cnt), 1);
    checkOutput("t2_relock_at_meas", 32'(lockRiseIdx), 5);
    checkOutput("t2_locked", 32'(mon_if.locked), 1);

    $display("[TB] stuck low");
    applyStimulus(80, 0, 1, -1);
    checkOutput("t3_err_count", 32'(errCount), 1);
    checkOutput("t3_err_step", 32'(errStep), 26);
    checkOutput("t3_meas_count", 32'(measCount), 0);
    checkOutput("t3_locked", 32'(mon_if.locked), 0);
    checkOutput("t3_err_cnt", 32'(mon_if.err_cnt), 2);
    applyStimulus(8, 4, 5, -1);
    checkOutput("t3r_meas_count", 32'(measCount), 4);
    checkOutput("t3r_lock_at_meas", 32'(lockRiseIdx), 4);
    checkOutput("t3r_err_count", 32'(errCount), 0);

    $display("[TB] duty fault");
    applyStimulus(8, 6, 2, -1);
    checkOutput("t4a_err_count", 32'(errCount), 1);
    checkOutput("t4a_locked", 32'(mon_if.locked), 0);
    applyStimulus(8, 6, 4, -1);
    checkOutput("t4_err_count", 32'(errCount), 4);
    checkOutput("t4_lock_rise", 32'(lockRiseIdx), 0);
    checkOutput("t4_high", 32'(lastHigh), 6);
    checkOutput("t4_err_cnt", 32'(mon_if.err_cnt), 7);

    $display("[TB] in-tolerance periods");
    applyStimulus(9, 5, 5, -1);
    checkOutput("t5a_err_count", 32'(errCount), 1);
    checkOutput("t5a_lock_at_meas", 32'(lockRiseIdx), 5);
    checkOutput("t5a_period", 32'(lastPeriod), 9);
    checkOutput("t5a_high", 32'(lastHigh), 5);
    applyStimulus(8, 6, 1, -1);
    checkOutput("t5b_err_count", 32'(errCount), 0);
    applyStimulus(7, 3, 5, -1);
    checkOutput("t5c_err_count", 32'(errCount), 1);
    checkOutput("t5c_lock_at_meas", 32'(lockRiseIdx), 5);
    checkOutput("t5c_period", 32'(lastPeriod), 7);
    checkOutput("t5c_high", 32'(lastHigh), 3);
    checkOutput("t5c_err_cnt", 32'(mon_if.err_cnt), 9);

    $display("[TB] error clear and mid-period reset");
    applyStimulus(8, 6, 1, -1);
    checkOutput("t6a_err_count", 32'(errCount), 0);
    applyStimulus(8, 4, 1, 2);
    checkOutput("t6b_err_count", 32'(errCount), 1);
    checkOutput("t6b_err_cnt", 32'(mon_if.err_cnt), 1);
    applyStimulus(8, 4, 1, 5);
    checkOutput("t6c_err_count", 32'(errCount), 0);
    checkOutput("t6c_err_cnt", 32'(mon_if.err_cnt), 0);
    checkOutput("t6c_period", 32'(mon_if.period_meas), 8);

    resetStats();
    driveCycle(1'b1, 1'b0);
    driveCycle(1'b1, 1'b0);
    rst = 1'b1;
    driveCycle(1'b1, 1'b0);
    rst = 1'b0;
    checkOutput("t6r_meas_valid", 32'(mon_if.meas_valid), 0);
    checkOutput("t6r_period", 32'(mon_if.period_meas), 0);
    checkOutput("t6r_high", 32'(mon_if.high_meas), 0);
    checkOutput("t6r_locked", 32'(mon_if.locked), 0);
    checkOutput("t6r_err", 32'(mon_if.err), 0);
    applyStimulus(6, 2, 1, -1);
    checkOutput("t6r_first_rise_meas", 32'(measCount), 0);
    checkOutput("t6r_first_rise_err", 32'(errCount), 0);
    checkOutput("t6r_period_after", 32'(mon_if.period_meas), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
